// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM access arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_BG   = 2'd1,
        OWN_OBJ  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] PPU_MODE_DRAW = 2'd3;

    // One candidate access as seen at grant time.
    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } acc_t;

    // True when a CPU-space address falls inside the VRAM window.
    function automatic logic in_vram(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          aw);
        logic [16:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < (17'd1 << aw));
    endfunction

endpackage

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM sequencer shared by bg fetcher, sprite fetcher and CPU.
// Latency: read accept->valid = 2+READ_LATENCY cycles; write = 2; blocked/out-of-range = 1.
// Backpressure: requesters hold req until their 1-cycle valid; one access in flight.
module vram_access_arbiter
    import vram_arb_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] VRAM_BASE    = 16'h8000,
    parameter int          VRAM_AW      = 13
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [1:0]         ppu_mode_in,
    input  logic               bg_req_in,
    input  logic [15:0]        bg_addr_in,
    input  logic               bg_lock_in,
    output logic [7:0]         bg_data_out,
    output logic               bg_valid_out,
    input  logic               obj_req_in,
    input  logic [15:0]        obj_addr_in,
    input  logic               obj_pending_in,
    output logic [7:0]         obj_data_out,
    output logic               obj_valid_out,
    input  logic               cpu_req_in,
    input  logic               cpu_we_in,
    input  logic [15:0]        cpu_addr_in,
    input  logic [7:0]         cpu_wdata_in,
    output logic [7:0]         cpu_rdata_out,
    output logic               cpu_valid_out,
    output logic               mem_en_out,
    output logic               mem_we_out,
    output logic [VRAM_AW-1:0] mem_addr_out,
    output logic [7:0]         mem_wdata_out,
    input  logic [7:0]         mem_rdata_in,
    output owner_t             owner_out
);

    localparam int               CNT_W     = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(READ_LATENCY);

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [VRAM_AW-1:0] maddr_q, maddr_d;
    logic               cpu_blk_q, cpu_blk_d;

    logic       cpu_locked;
    owner_t     gnt;
    acc_t       sel;
    logic       sel_hit;

    logic       ld_vld;
    owner_t     ld_own;
    logic [7:0] ld_dat;

    logic [7:0] bg_dat_q, obj_dat_q, cpu_dat_q;

    // Priority pick among requesters; a bg burst lock keeps obj out until it drops.
    always_comb begin
        cpu_locked = (ppu_mode_in == PPU_MODE_DRAW);
        gnt        = OWN_NONE;
        if (bg_req_in && bg_lock_in) begin
            gnt = OWN_BG;
        end else if (obj_req_in && obj_pending_in && !bg_lock_in) begin
            gnt = OWN_OBJ;
        end else if (bg_req_in) begin
            gnt = OWN_BG;
        end else if (obj_req_in && !bg_lock_in) begin
            gnt = OWN_OBJ;
        end else if (cpu_req_in && !cpu_locked) begin
            gnt = OWN_CPU;
        end

        sel = '{addr: 16'h0000, we: 1'b0, wdata: 8'h00};
        case (gnt)
            OWN_BG:  sel.addr = bg_addr_in;
            OWN_OBJ: sel.addr = obj_addr_in;
            OWN_CPU: sel = '{addr: cpu_addr_in, we: cpu_we_in, wdata: cpu_wdata_in};
            default: ;
        endcase
        sel_hit = in_vram(sel.addr, VRAM_BASE, VRAM_AW);
    end

    // Next-state and response-data load selection.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        maddr_d   = maddr_q;
        cpu_blk_d = 1'b0;
        ld_vld    = 1'b0;
        ld_own    = OWN_NONE;
        ld_dat    = 8'h00;

        case (state_q)
            IDLE: begin
                if (gnt != OWN_NONE) begin
                    owner_d = gnt;
                    we_d    = sel.we;
                    if (sel_hit) begin
                        state_d = ISSUE;
                        wdata_d = sel.wdata;
                        maddr_d = VRAM_AW'(sel.addr - VRAM_BASE);
                        // A locked-out CPU is answered alongside the PPU grant.
                        if (cpu_req_in && cpu_locked) begin
                            cpu_blk_d = 1'b1;
                            ld_vld    = !cpu_we_in;
                            ld_own    = OWN_CPU;
                            ld_dat    = 8'hFF;
                        end
                    end else begin
                        // Out-of-window: answer directly, no BRAM cycle.
                        state_d = RESP;
                        ld_vld  = !sel.we;
                        ld_own  = gnt;
                        ld_dat  = 8'hFF;
                    end
                end else if (cpu_req_in && cpu_locked) begin
                    owner_d = OWN_CPU;
                    we_d    = cpu_we_in;
                    state_d = RESP;
                    ld_vld  = !cpu_we_in;
                    ld_own  = OWN_CPU;
                    ld_dat  = 8'hFF;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_FIRST;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    ld_vld  = 1'b1;
                    ld_own  = owner_q;
                    ld_dat  = mem_rdata_in;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // FSM and access registers; reset abandons any in-flight access.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
            maddr_q   <= '0;
            cpu_blk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            maddr_q   <= maddr_d;
            cpu_blk_q <= cpu_blk_d;
        end
    end

    // Per-requester response data, held until that requester's next response.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bg_dat_q  <= 8'h00;
            obj_dat_q <= 8'h00;
            cpu_dat_q <= 8'h00;
        end else if (ld_vld) begin
            case (ld_own)
                OWN_BG:  bg_dat_q  <= ld_dat;
                OWN_OBJ: obj_dat_q <= ld_dat;
                OWN_CPU: cpu_dat_q <= ld_dat;
                default: ;
            endcase
        end
    end

    assign mem_en_out    = (state_q == ISSUE);
    assign mem_we_out    = (state_q == ISSUE) && we_q;
    assign mem_addr_out  = maddr_q;
    assign mem_wdata_out = wdata_q;

    assign bg_valid_out  = (state_q == RESP) && (owner_q == OWN_BG);
    assign obj_valid_out = (state_q == RESP) && (owner_q == OWN_OBJ);
    assign cpu_valid_out = ((state_q == RESP) && (owner_q == OWN_CPU)) || cpu_blk_q;

    assign bg_data_out   = bg_dat_q;
    assign obj_data_out  = obj_dat_q;
    assign cpu_rdata_out = cpu_dat_q;
    assign owner_out     = owner_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
module tb_vram_access_arbiter;
    import vram_arb_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [1:0]  ppu_mode_in = 2'd0;
    logic        bg_req_in = 1'b0;
    logic [15:0] bg_addr_in = 16'h0000;
    logic        bg_lock_in = 1'b0;
    logic [7:0]  bg_data_out;
    logic        bg_valid_out;
    logic        obj_req_in = 1'b0;
    logic [15:0] obj_addr_in = 16'h0000;
    logic        obj_pending_in = 1'b0;
    logic [7:0]  obj_data_out;
    logic        obj_valid_out;
    logic        cpu_req_in = 1'b0;
    logic        cpu_we_in = 1'b0;
    logic [15:0] cpu_addr_in = 16'h0000;
    logic [7:0]  cpu_wdata_in = 8'h00;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_valid_out;
    logic        mem_en_out;
    logic        mem_we_out;
    logic [12:0] mem_addr_out;
    logic [7:0]  mem_wdata_out;
    logic [7:0]  mem_rdata_in;
    owner_t      owner_out;

    int checks = 0;
    int fails  = 0;
    int en_count = 0;
    int en_mark;
    logic mon_on = 1'b0;

    logic [7:0] vram [8192];
    logic [7:0] rdata_q = 8'h00;
    assign mem_rdata_in = rdata_q;

    vram_access_arbiter #(.READ_LATENCY(1), .VRAM_BASE(16'h8000), .VRAM_AW(13)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .ppu_mode_in(ppu_mode_in),
        .bg_req_in(bg_req_in), .bg_addr_in(bg_addr_in), .bg_lock_in(bg_lock_in),
        .bg_data_out(bg_data_out), .bg_valid_out(bg_valid_out),
        .obj_req_in(obj_req_in), .obj_addr_in(obj_addr_in), .obj_pending_in(obj_pending_in),
        .obj_data_out(obj_data_out), .obj_valid_out(obj_valid_out),
        .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_addr_in(cpu_addr_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_rdata_out(cpu_rdata_out), .cpu_valid_out(cpu_valid_out),
        .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .owner_out(owner_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model with one cycle of read latency.
    always @(posedge clk_in) begin
        if (mem_en_out) begin
            en_count = en_count + 1;
            if (mem_we_out) vram[mem_addr_out] = mem_wdata_out;
            else            rdata_q <= vram[mem_addr_out];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    // At most one requester valid per cycle.
    always @(negedge clk_in) begin
        if (mon_on)
            chk("valid_onehot",
                32'((int'(bg_valid_out) + int'(obj_valid_out) + int'(cpu_valid_out)) > 1), 32'd0);
    end

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = 8'(i) ^ 8'h5A;
        vram[13'h0000] = 8'h11;
        vram[13'h0010] = 8'hA5;
        vram[13'h0020] = 8'hC3;
        vram[13'h0030] = 8'hB1;
        vram[13'h0040] = 8'hE7;
        vram[13'h1800] = 8'h5A;

        // Reset state
        #2;
        chk("rst_owner", 32'(owner_out), 32'(OWN_NONE));
        chk("rst_en", 32'(mem_en_out), 0);
        chk("rst_valids", 32'({bg_valid_out, obj_valid_out, cpu_valid_out, mem_we_out}), 0);
        chk("rst_data", {bg_data_out, obj_data_out, cpu_rdata_out}, 0);
        chk("rst_addr", 32'(mem_addr_out), 0);
        #21 rst_n_in = 1'b1;
        mon_on = 1'b1;

        // T1: mode 0 CPU read 8010 -> A5 at N+3
        step(); cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8010;
        smp(); chk("t1_n_en", 32'(mem_en_out), 0);
        step(); smp();
        chk("t1_en", 32'(mem_en_out), 1);
        chk("t1_addr", 32'(mem_addr_out), 32'h10);
        chk("t1_owner", 32'(owner_out), 32'(OWN_CPU));
        step(); smp(); chk("t1_early_vld", 32'(cpu_valid_out), 0);
        step(); cpu_req_in = 1'b0; smp();
        chk("t1_vld", 32'(cpu_valid_out), 1);
        chk("t1_rdata", 32'(cpu_rdata_out), 32'hA5);
        step(); smp();
        chk("t1_vld_off", 32'(cpu_valid_out), 0);
        chk("t1_owner_off", 32'(owner_out), 32'(OWN_NONE));

        // T2: mode 3 CPU write 8000 blocked, valid at N+1, no BRAM access
        en_mark = en_count;
        step(); ppu_mode_in = 2'd3; cpu_req_in = 1'b1; cpu_we_in = 1'b1;
        cpu_addr_in = 16'h8000; cpu_wdata_in = 8'h3C;
        smp();
        step(); cpu_req_in = 1'b0; smp();
        chk("t2_vld", 32'(cpu_valid_out), 1);
        chk("t2_en", 32'(mem_en_out), 0);
        step(); smp();
        chk("t2_vld_off", 32'(cpu_valid_out), 0);
        chk("t2_no_access", 32'(en_count - en_mark), 0);
        chk("t2_bram0", 32'(vram[0]), 32'h11);

        // T3: mode 3 CPU read 9800 blocked -> FF at N+1
        step(); cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h9800; smp();
        step(); cpu_req_in = 1'b0; smp();
        chk("t3_vld", 32'(cpu_valid_out), 1);
        chk("t3_rdata", 32'(cpu_rdata_out), 32'hFF);
        chk("t3_no_access", 32'(en_count - en_mark), 0);

        // T3b: mode 0 read back 8000, write above left it alone
        step(); ppu_mode_in = 2'd0; cpu_req_in = 1'b1; cpu_addr_in = 16'h8000; smp();
        step(); smp(); step(); smp();
        step(); cpu_req_in = 1'b0; smp();
        chk("t3b_vld", 32'(cpu_valid_out), 1);
        chk("t3b_rdata", 32'(cpu_rdata_out), 32'h11);

        // T3c: mode 0 CPU write 8050 <- 77: en+we at N+1, valid at N+2
        step(); cpu_req_in = 1'b1; cpu_we_in = 1'b1; cpu_addr_in = 16'h8050; cpu_wdata_in = 8'h77; smp();
        step(); smp();
        chk("t3c_en_we", 32'({mem_en_out, mem_we_out}), 32'h3);
        chk("t3c_addr", 32'(mem_addr_out), 32'h50);
        chk("t3c_wdata", 32'(mem_wdata_out), 32'h77);
        step(); cpu_req_in = 1'b0; smp();
        chk("t3c_vld", 32'(cpu_valid_out), 1);
        chk("t3c_bram", 32'(vram[13'h0050]), 32'h77);

        // T3d: mode 0 out-of-range read A000 -> FF at N+1, no access
        en_mark = en_count;
        step(); cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'hA000; smp();
        step(); cpu_req_in = 1'b0; smp();
        chk("t3d_vld", 32'(cpu_valid_out), 1);
        chk("t3d_rdata", 32'(cpu_rdata_out), 32'hFF);
        chk("t3d_no_access", 32'(en_count - en_mark), 0);

        // T4: mode 3, bg locked burst vs pending obj, with a blocked CPU alongside
        step(); ppu_mode_in = 2'd3;
        bg_lock_in = 1'b1; bg_req_in = 1'b1; bg_addr_in = 16'h9800;
        obj_pending_in = 1'b1; obj_req_in = 1'b1; obj_addr_in = 16'h8020;
        cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8010;
        smp();
        step(); cpu_req_in = 1'b0; smp();
        chk("t4_owner_bg", 32'(owner_out), 32'(OWN_BG));
        chk("t4_addr", 32'(mem_addr_out), 32'h1800);
        chk("t4_cpu_blk_vld", 32'(cpu_valid_out), 1);
        chk("t4_cpu_blk_data", 32'(cpu_rdata_out), 32'hFF);
        step(); smp();
        step(); bg_req_in = 1'b0; smp();
        chk("t4_bg_vld", 32'(bg_valid_out), 1);
        chk("t4_bg_data", 32'(bg_data_out), 32'h5A);
        step(); smp(); chk("t4_obj_wait1", 32'(owner_out), 32'(OWN_NONE));
        step(); bg_lock_in = 1'b0; smp();
        chk("t4_obj_wait2", 32'(mem_en_out), 0);
        step(); smp();
        chk("t4_owner_obj", 32'(owner_out), 32'(OWN_OBJ));
        chk("t4_obj_addr", 32'(mem_addr_out), 32'h20);
        step(); smp();
        step(); obj_req_in = 1'b0; obj_pending_in = 1'b0; smp();
        chk("t4_obj_vld", 32'(obj_valid_out), 1);
        chk("t4_obj_data", 32'(obj_data_out), 32'hC3);

        // T5: mode 0, bg+obj together with pending -> obj first
        step(); ppu_mode_in = 2'd0;
        bg_req_in = 1'b1; bg_addr_in = 16'h8030;
        obj_req_in = 1'b1; obj_pending_in = 1'b1; obj_addr_in = 16'h8040;
        smp();
        step(); smp();
        chk("t5_owner_obj", 32'(owner_out), 32'(OWN_OBJ));
        chk("t5_addr_obj", 32'(mem_addr_out), 32'h40);
        step(); smp(); chk("t5_bg_quiet1", 32'(bg_valid_out), 0);
        step(); obj_req_in = 1'b0; obj_pending_in = 1'b0; smp();
        chk("t5_obj_vld", 32'(obj_valid_out), 1);
        chk("t5_obj_data", 32'(obj_data_out), 32'hE7);
        chk("t5_bg_quiet2", 32'(bg_valid_out), 0);
        step(); smp();
        step(); smp();
        chk("t5_owner_bg", 32'(owner_out), 32'(OWN_BG));
        chk("t5_addr_bg", 32'(mem_addr_out), 32'h30);
        step(); smp();
        step(); smp();
        chk("t5_bg_vld", 32'(bg_valid_out), 1);
        chk("t5_bg_data", 32'(bg_data_out), 32'hB1);

        // T6: async reset in WAIT; held bg_req restarts from IDLE
        step(); bg_addr_in = 16'h8020; smp();   // bg_req still held; RESP ignores it
        step(); smp();
        chk("t6_issue", 32'(mem_en_out), 1);
        step();                                   // WAIT
        #3 rst_n_in = 1'b0;
        #1;
        chk("t6_rst_owner", 32'(owner_out), 32'(OWN_NONE));
        chk("t6_rst_en", 32'(mem_en_out), 0);
        chk("t6_rst_valids", 32'({bg_valid_out, obj_valid_out, cpu_valid_out}), 0);
        chk("t6_rst_data", 32'(bg_data_out), 0);
        #7 rst_n_in = 1'b1;
        step(); smp();
        chk("t6_re_owner", 32'(owner_out), 32'(OWN_BG));
        chk("t6_re_en", 32'(mem_en_out), 1);
        step(); smp(); chk("t6_re_wait", 32'(bg_valid_out), 0);
        step(); bg_req_in = 1'b0; smp();
        chk("t6_re_vld", 32'(bg_valid_out), 1);
        chk("t6_re_data", 32'(bg_data_out), 32'hC3);
        step(); smp();
        chk("t6_idle", 32'(owner_out), 32'(OWN_NONE));
        mon_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
